// File: rtl/msb_window_controller.sv
// Start/abort-controlled MSB statistics run: clear, count zeros/ones over WINDOW valid
// samples, latch results and pulse done. Optional bias verdict under BIAS_CHECK_EN.
module msb_window_controller #(
  parameter int CNT_W  = 17,
  parameter int WINDOW = 100000,
  parameter int THRESH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             sample_valid,
  input  logic             msb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_zero,
  output logic [CNT_W-1:0] count_one,
  output logic             bias_flag
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_CLEAR | one cycle, internal counters cleared
  // S_RUN   | counting valid samples until WINDOW reached
  // S_DONE  | one cycle, done pulse, results already latched
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  localparam int              SCW         = $clog2(WINDOW + 1);
  localparam logic [SCW-1:0]  LAST_SAMPLE = SCW'(WINDOW - 1);

  state_t           state;
  logic [CNT_W-1:0] zero_cnt;
  logic [CNT_W-1:0] one_cnt;
  logic [CNT_W-1:0] zero_nx;
  logic [CNT_W-1:0] one_nx;
  logic [SCW-1:0]   sample_cnt;
  logic             is_one;
  logic             last_sample;
  logic             bias_nx;

  // Next counts include the sample being accepted this cycle, so DONE entry latches finals.
  always_comb begin
    is_one      = (msb == 1'b1);
    zero_nx     = zero_cnt + {{(CNT_W-1){1'b0}}, ~is_one};
    one_nx      = one_cnt + {{(CNT_W-1){1'b0}}, is_one};
    last_sample = (sample_cnt == LAST_SAMPLE);
  end

`ifdef BIAS_CHECK_EN
  localparam logic [31:0] THRESH_U = 32'(THRESH);
  logic signed [CNT_W:0] diff;
  logic        [CNT_W:0] mag;

  always_comb begin
    diff    = $signed({1'b0, one_nx}) - $signed({1'b0, zero_nx});
    mag     = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    bias_nx = ({{(31-CNT_W){1'b0}}, mag} > THRESH_U);
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign bias_nx       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      count_zero <= '0;
      count_one  <= '0;
      bias_flag  <= 1'b0;
      zero_cnt   <= '0;
      one_cnt    <= '0;
      sample_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_CLEAR;
            busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          zero_cnt   <= '0;
          one_cnt    <= '0;
          sample_cnt <= '0;
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // abort wins over a completing sample on the same edge
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (sample_valid) begin
            zero_cnt   <= zero_nx;
            one_cnt    <= one_nx;
            sample_cnt <= sample_cnt + SCW'(1);
            if (last_sample) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              count_zero <= zero_nx;
              count_one  <= one_nx;
              bias_flag  <= bias_nx;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msb_window_controller.sv
// Directed bench for msb_window_controller with WINDOW=8, CNT_W=5, THRESH=4.
module tb_msb_window_controller;

  localparam int CW = 5;
`ifdef BIAS_CHECK_EN
  localparam logic BIAS_ON = 1'b1;
`else
  localparam logic BIAS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, abort, sample_valid, msb;
  logic          busy, done, bias_flag;
  logic [CW-1:0] count_zero, count_one;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  msb_window_controller #(.CNT_W(CW), .WINDOW(8), .THRESH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .sample_valid(sample_valid), .msb(msb), .busy(busy), .done(done),
    .count_zero(count_zero), .count_one(count_one), .bias_flag(bias_flag)
  );

  // mode 0: valid every cycle, msb alternating 1,0; mode 1: valid every other cycle, msb=0;
  // mode 2: valid every cycle, msb=1. lat = edges from the start-sampling edge to done.
  task automatic do_run(input int mode, input int abort_at, input int restart_j,
                        input int reset_j, output int lat, output bit got_done,
                        output int busy_err);
    int acc;
    acc = 0; lat = 0; got_done = 1'b0; busy_err = 0;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; sample_valid = 1'b0; msb = 1'b0;
    @(posedge clk);
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      start        = (j == restart_j);
      reset        = (j == reset_j);
      sample_valid = (mode == 1) ? j[0] : 1'b1;
      msb          = (mode == 2) ? 1'b1 : ((mode == 0) ? j[0] : 1'b0);
      abort        = (abort_at >= 0 && j >= 1 && acc == abort_at);
      @(posedge clk); #1;
      if (j >= 1 && sample_valid && !abort) acc++;
      if (abort || reset) break;
      if (done) begin
        got_done = 1'b1;
        lat = j + 1;
        break;
      end
      if (busy !== 1'b1) busy_err++;
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    start = 1'b0; abort = 1'b0; reset = 1'b0; sample_valid = 1'b0; msb = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; sample_valid = 1'b0; msb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (count_zero !== 5'd0) begin bad++; $display("FAIL reset_cz got=%0d exp=0", count_zero); end
    total++; if (count_one !== 5'd0) begin bad++; $display("FAIL reset_co got=%0d exp=0", count_one); end
    total++; if (bias_flag !== 1'b0) begin bad++; $display("FAIL reset_bias got=%b exp=0", bias_flag); end
  endtask

  task automatic test_alternate();
    int lat, berr; bit gd;
    do_run(0, -1, -1, -1, lat, gd, berr);
    total++; if (gd !== 1'b1) begin bad++; $display("FAIL alt_done got=%b exp=1", gd); end
    total++; if (lat != 9) begin bad++; $display("FAIL alt_latency got=%0d exp=9", lat); end
    total++; if (berr != 0) begin bad++; $display("FAIL alt_busy_during_run got=%0d exp=0", berr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL alt_busy_at_done got=%b exp=0", busy); end
    total++; if (count_zero !== 5'd4) begin bad++; $display("FAIL alt_cz got=%0d exp=4", count_zero); end
    total++; if (count_one !== 5'd4) begin bad++; $display("FAIL alt_co got=%0d exp=4", count_one); end
    total++; if (bias_flag !== 1'b0) begin bad++; $display("FAIL alt_bias got=%b exp=0", bias_flag); end
    idle_inputs();
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL alt_done_one_cycle got=%b exp=0", done); end
  endtask

  task automatic test_toggle_valid();
    int lat, berr; bit gd;
    do_run(1, -1, -1, -1, lat, gd, berr);
    total++; if (gd !== 1'b1) begin bad++; $display("FAIL tog_done got=%b exp=1", gd); end
    total++; if (lat != 16) begin bad++; $display("FAIL tog_latency got=%0d exp=16", lat); end
    total++; if (count_zero !== 5'd8) begin bad++; $display("FAIL tog_cz got=%0d exp=8", count_zero); end
    total++; if (count_one !== 5'd0) begin bad++; $display("FAIL tog_co got=%0d exp=0", count_one); end
    total++; if (bias_flag !== BIAS_ON) begin bad++; $display("FAIL tog_bias got=%b exp=%b", bias_flag, BIAS_ON); end
    idle_inputs();
  endtask

  task automatic test_abort();
    int lat, berr, done_seen; bit gd;
    test_alternate();
    do_run(0, 3, -1, -1, lat, gd, berr);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    idle_inputs();
    done_seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    total++; if (gd !== 1'b0 || done_seen != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_seen + gd); end
    total++; if (count_zero !== 5'd4) begin bad++; $display("FAIL abort_cz got=%0d exp=4", count_zero); end
    total++; if (count_one !== 5'd4) begin bad++; $display("FAIL abort_co got=%0d exp=4", count_one); end
  endtask

  task automatic test_start_ignored();
    int lat, berr, busy_seen; bit gd;
    do_run(2, -1, 3, -1, lat, gd, berr);
    total++; if (lat != 9) begin bad++; $display("FAIL restart_latency got=%0d exp=9", lat); end
    total++; if (count_one !== 5'd8) begin bad++; $display("FAIL restart_co got=%0d exp=8", count_one); end
    idle_inputs();
    busy_seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy === 1'b1) busy_seen++;
    end
    total++; if (busy_seen != 0) begin bad++; $display("FAIL restart_not_queued got=%0d exp=0", busy_seen); end
  endtask

  task automatic test_reset_midrun();
    int lat, berr; bit gd;
    do_run(0, -1, 2, 5, lat, gd, berr);
    idle_inputs();
    @(posedge clk); #1;
    total++; if (gd !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b exp=0", gd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (count_zero !== 5'd0) begin bad++; $display("FAIL rst_mid_cz got=%0d exp=0", count_zero); end
    total++; if (count_one !== 5'd0) begin bad++; $display("FAIL rst_mid_co got=%0d exp=0", count_one); end
    total++; if (bias_flag !== 1'b0) begin bad++; $display("FAIL rst_mid_bias got=%b exp=0", bias_flag); end
  endtask

  task automatic test_bias();
    int lat, berr; bit gd;
    do_run(2, -1, -1, -1, lat, gd, berr);
    total++; if (gd !== 1'b1) begin bad++; $display("FAIL bias1_done got=%b exp=1", gd); end
    total++; if (count_one !== 5'd8) begin bad++; $display("FAIL bias1_co got=%0d exp=8", count_one); end
    total++; if (count_zero !== 5'd0) begin bad++; $display("FAIL bias1_cz got=%0d exp=0", count_zero); end
    total++; if (bias_flag !== BIAS_ON) begin bad++; $display("FAIL bias1_flag got=%b exp=%b", bias_flag, BIAS_ON); end
    idle_inputs();
    do_run(0, -1, -1, -1, lat, gd, berr);
    total++; if (count_one !== 5'd4) begin bad++; $display("FAIL bias2_co got=%0d exp=4", count_one); end
    total++; if (bias_flag !== 1'b0) begin bad++; $display("FAIL bias2_flag got=%b exp=0", bias_flag); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_toggle_valid();
    test_abort();
    test_start_ignored();
    test_reset_midrun();
    test_bias();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
